ctrl_sequencer: RTL and testbench



---
 rtl/ctrl_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired fetch/decode/execute control unit for ALUSystem.
// Each instruction is fetched as two IR bytes (low byte, then high byte).
// It then executes in one further cycle.
// Outputs are decoded combinationally from the state register, IROut and zlatch.
// While Reset is high, the idle vector is forced in the same cycle.
// Optional feature: define CTRL_INSTR_COUNT_EN to add the retired-instruction
// counter and its InstrCount port.
module ctrl_sequencer #(
  parameter int WIDTH_CNT = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [15:0]          IROut,
  input  logic [3:0]           ALUOutFlag,
  output logic [1:0]           RF_OutASel,
  output logic [1:0]           RF_OutBSel,
  output logic [1:0]           RF_FunSel,
  output logic [3:0]           RF_RegSel,
  output logic [3:0]           ALU_FunSel,
  output logic [1:0]           ARF_OutCSel,
  output logic [1:0]           ARF_OutDSel,
  output logic [1:0]           ARF_FunSel,
  output logic [2:0]           ARF_RegSel,
  output logic                 IR_LH,
  output logic                 IR_Enable,
  output logic [1:0]           IR_Funsel,
  output logic                 Mem_WR,
  output logic                 Mem_CS,
  output logic [1:0]           MuxASel,
  output logic [1:0]           MuxBSel,
  output logic                 MuxCSel
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [WIDTH_CNT-1:0] InstrCount
`endif
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t     state;
  logic       zlatch;
  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [3:0] rd_onehot;
  logic       unused_bits;

  assign opcode    = IROut[15:12];
  assign rd        = IROut[11:10];
  assign ra        = IROut[9:8];
  assign rb        = IROut[7:6];
  assign rd_onehot = 4'b0001 << rd;

  // The immediate byte reaches the datapath through MuxA/MuxB, and only the Z flag steers control.
  assign unused_bits = ^{IROut[5:0], ALUOutFlag[2:0]};

  // Map opcodes 4..7 (ADD/SUB/AND/OR) onto ALU function codes.
  function automatic logic [3:0] alu_code(input logic [1:0] sel);
    case (sel)
      2'd0:    alu_code = 4'b0100;
      2'd1:    alu_code = 4'b0110;
      2'd2:    alu_code = 4'b0111;
      default: alu_code = 4'b1000;
    endcase
  endfunction

  // Sequence state and Z-flag latch; Z is captured only at the end of ALU instructions.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_INIT;
      zlatch <= 1'b0;
    end else begin
      case (state)
        S_INIT:    state <= S_FETCH_L;
        S_FETCH_L: state <= S_FETCH_H;
        S_FETCH_H: state <= S_EXEC;
        S_EXEC: begin
          if (opcode[3:2] == 2'b01) zlatch <= ALUOutFlag[3];
          state <= (opcode == 4'hF) ? S_HALT : S_FETCH_L;
        end
        default:   state <= S_HALT;
      endcase
    end
  end

`ifdef CTRL_INSTR_COUNT_EN
  // Count retired instructions at the end of every EXEC cycle; frozen in HALT.
  always_ff @(posedge Clock) begin
    if (Reset)                InstrCount <= '0;
    else if (state == S_EXEC) InstrCount <= InstrCount + 1'b1;
  end
`endif

  // Decode the control vector; Reset and HALT leave the idle vector in place.
  always_comb begin
    RF_OutASel  = 2'b00;
    RF_OutBSel  = 2'b00;
    RF_FunSel   = 2'b00;
    RF_RegSel   = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    if (!Reset) begin
      case (state)
        S_INIT: begin
          RF_RegSel  = 4'b1111;
          ARF_RegSel = 3'b111;
          IR_Enable  = 1'b1;
        end
        S_FETCH_L, S_FETCH_H: begin
          Mem_CS     = 1'b0;
          IR_LH      = (state == S_FETCH_H);
          IR_Enable  = 1'b1;
          IR_Funsel  = 2'b01;
          ARF_RegSel = 3'b001;
          ARF_FunSel = 2'b11;
        end
        S_EXEC: begin
          case (opcode)
            4'h1: begin
              RF_RegSel = rd_onehot;
              MuxASel   = 2'b10;
              RF_FunSel = 2'b01;
            end
            4'h2: begin
              RF_RegSel   = rd_onehot;
              Mem_CS      = 1'b0;
              ARF_OutDSel = 2'b01;
              MuxASel     = 2'b01;
              RF_FunSel   = 2'b01;
            end
            4'h3: begin
              RF_OutASel  = rd;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
              ARF_OutDSel = 2'b01;
            end
            4'h4, 4'h5, 4'h6, 4'h7: begin
              RF_OutASel = ra;
              RF_OutBSel = rb;
              ALU_FunSel = alu_code(opcode[1:0]);
              RF_RegSel  = rd_onehot;
              RF_FunSel  = 2'b01;
            end
            4'h8: begin
              RF_RegSel = rd_onehot;
              RF_FunSel = 2'b11;
            end
            4'h9: begin
              RF_RegSel = rd_onehot;
              RF_FunSel = 2'b10;
            end
            4'hA, 4'hB: begin
              if (opcode[0] || zlatch) begin
                MuxBSel    = 2'b10;
                ARF_RegSel = 3'b001;
                ARF_FunSel = 2'b01;
              end
            end
            4'hC: begin
              MuxBSel    = 2'b10;
              ARF_RegSel = 3'b010;
              ARF_FunSel = 2'b01;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed and randomized bench for ctrl_sequencer.
// The reference tracks the position inside an instruction as a cycle count since reset.
// The reference computes the expected control vector from the opcode rules.
module tb_ctrl_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel;
  logic [1:0]  IR_Funsel, MuxASel, MuxBSel;
`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] InstrCount;
`endif

  always #5 Clock = ~Clock;

  ctrl_sequencer #(.WIDTH_CNT(16)) dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
`ifdef CTRL_INSTR_COUNT_EN
    , .InstrCount(InstrCount)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference state: cycles since reset release, halt flag, Z latch and retired count.
  int          t = 0;
  bit          halted = 1'b0;
  bit          zl = 1'b0;
  logic [15:0] cnt = '0;

  logic [33:0] obs;
  assign obs = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel, ARF_OutCSel,
                ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable, IR_Funsel,
                Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // 0 = INIT, 1 = low fetch, 2 = high fetch, 3 = execute, 4 = idle.
  function automatic int phase();
    if (halted) return 4;
    if (t == 0) return 0;
    return 1 + ((t - 1) % 3);
  endfunction

  function automatic logic [33:0] ref_vec(input int ph, input logic [15:0] ir, input bit z);
    logic [1:0] rfa, rfb, rffs, arfc, arfd, arffs, irfs, muxa, muxb;
    logic [3:0] rfrs, alufs, op, dsel;
    logic [2:0] arfrs;
    logic       lh, en, wr, cs, muxc;
    rfa = 0; rfb = 0; rffs = 0; arfc = 0; arfd = 0; arffs = 0; irfs = 0; muxa = 0; muxb = 0;
    rfrs = 0; alufs = 0; arfrs = 0; lh = 0; en = 0; wr = 0; cs = 1; muxc = 0;
    op   = ir[15:12];
    dsel = 4'(1 << ir[11:10]);
    if (ph == 0) begin
      rfrs = 4'hF; arfrs = 3'h7; en = 1;
    end else if (ph == 1 || ph == 2) begin
      cs = 0; lh = (ph == 2); en = 1; irfs = 1; arfrs = 1; arffs = 3;
    end else if (ph == 3) begin
      if (op == 1) begin rfrs = dsel; muxa = 2; rffs = 1; end
      else if (op == 2) begin rfrs = dsel; cs = 0; arfd = 1; muxa = 1; rffs = 1; end
      else if (op == 3) begin rfa = ir[11:10]; cs = 0; wr = 1; arfd = 1; end
      else if (op >= 4 && op <= 7) begin
        rfa = ir[9:8]; rfb = ir[7:6]; rfrs = dsel; rffs = 1;
        alufs = (op == 4) ? 4'b0100 : (op == 5) ? 4'b0110 : (op == 6) ? 4'b0111 : 4'b1000;
      end
      else if (op == 8) begin rfrs = dsel; rffs = 3; end
      else if (op == 9) begin rfrs = dsel; rffs = 2; end
      else if ((op == 10 && z) || op == 11) begin muxb = 2; arfrs = 1; arffs = 1; end
      else if (op == 12) begin muxb = 2; arfrs = 2; arffs = 1; end
    end
    return {rfa, rfb, rffs, rfrs, alufs, arfc, arfd, arffs, arfrs, lh, en, irfs, wr, cs,
            muxa, muxb, muxc};
  endfunction

  // Apply inputs, then compare the whole control vector at the falling edge.
  task automatic drive_check(input logic r, input logic [15:0] ir, input logic [3:0] fl);
    Reset = r; IROut = ir; ALUOutFlag = fl;
    @(negedge Clock);
    chk($sformatf("vec_ph%0d_ir%04h", r ? 4 : phase(), ir), 64'(obs),
        64'(ref_vec(r ? 4 : phase(), ir, zl)));
`ifdef CTRL_INSTR_COUNT_EN
    chk("instr_count", 64'(InstrCount), 64'(cnt));
`endif
  endtask

  // Advance the reference across a rising edge.
  task automatic clock_edge();
    @(posedge Clock);
    if (Reset) begin
      t = 0; halted = 0; zl = 0; cnt = '0;
    end else if (!halted) begin
      if (phase() == 3) begin
        cnt++;
        if (IROut[15:12] >= 4 && IROut[15:12] <= 7) zl = ALUOutFlag[3];
        if (IROut[15:12] == 4'hF) halted = 1;
      end
      t++;
    end
    #1;
  endtask

  task automatic cyc(input logic r, input logic [15:0] ir, input logic [3:0] fl);
    drive_check(r, ir, fl);
    clock_edge();
  endtask

  initial begin
    logic [15:0] rir;
    logic        rr;
    // Two reset cycles.
    cyc(1, 16'h0000, 4'h0);
    drive_check(1, 16'h3000, 4'h0);
    chk("reset_mem_cs", 64'(Mem_CS), 64'd1);
    clock_edge();
    // INIT then first FETCH_L.
    drive_check(0, 16'h0000, 4'h0);
    chk("init_rf_regsel", 64'(RF_RegSel), 64'hF);
    chk("init_arf_regsel", 64'(ARF_RegSel), 64'h7);
    chk("init_funsels", 64'({RF_FunSel, ARF_FunSel, IR_Funsel}), 64'd0);
    clock_edge();
    drive_check(0, 16'h0000, 4'h0);
    chk("fetchl_vec", 64'({Mem_CS, IR_Enable, IR_LH, ARF_RegSel, ARF_FunSel}), 64'b0_1_0_001_11);
    clock_edge();
    cyc(0, 16'h0000, 4'h0);
    // LDI R2,0x5A.
    drive_check(0, 16'h185A, 4'h0);
    chk("ldi_vec", 64'({RF_RegSel, MuxASel, RF_FunSel, Mem_CS}), 64'b0100_10_01_1);
    clock_edge();
    // SUB R1=R2-R3 with Z set, then BRZ taken.
    cyc(0, 16'h0000, 4'h0); cyc(0, 16'h0000, 4'h0);
    drive_check(0, 16'h56C0, 4'h8);
    chk("sub_vec", 64'({ALU_FunSel, RF_OutASel, RF_OutBSel}), 64'b0110_10_11);
    clock_edge();
    cyc(0, 16'h0000, 4'h0); cyc(0, 16'h0000, 4'h0);
    drive_check(0, 16'hA040, 4'h0);
    chk("brz_taken", 64'({ARF_RegSel, MuxBSel}), 64'b001_10);
    clock_edge();
    // SUB with Z clear, then BRZ not taken and the following fetch.
    cyc(0, 16'h0000, 4'h0); cyc(0, 16'h0000, 4'h0);
    cyc(0, 16'h56C0, 4'h0);
    cyc(0, 16'h0000, 4'h0); cyc(0, 16'h0000, 4'h0);
    drive_check(0, 16'hA040, 4'h0);
    chk("brz_not_taken", 64'(ARF_RegSel), 64'd0);
    clock_edge();
    drive_check(0, 16'hA040, 4'h0);
    chk("after_brz_fetch", 64'({Mem_CS, IR_Enable, ARF_FunSel}), 64'b0_1_11);
    clock_edge();
    // HLT, then 20 idle cycles.
    cyc(0, 16'h0000, 4'h0);
    cyc(0, 16'hF000, 4'h0);
    for (int i = 0; i < 20; i++) cyc(0, 16'($urandom), 4'($urandom));
    drive_check(0, 16'h185A, 4'h8);
    chk("halt_idle", 64'({RF_RegSel, ARF_RegSel, IR_Enable, Mem_CS, Mem_WR}), 64'b0000_000_0_1_0);
    clock_edge();
    // Reset pulse leaves HALT through INIT.
    cyc(1, 16'h0000, 4'h0);
    drive_check(0, 16'h0000, 4'h0);
    chk("halt_exit_init", 64'(RF_RegSel), 64'hF);
    clock_edge();
    // Three instructions, then reset during FETCH_H.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0000, 4'h0); cyc(0, 16'h0000, 4'h0);
      cyc(0, (i == 1) ? 16'h0000 : 16'h8400, 4'h0);
    end
`ifdef CTRL_INSTR_COUNT_EN
    drive_check(0, 16'h3000, 4'h0);
    chk("count_three", 64'(InstrCount), 64'd3);
    clock_edge();
`else
    cyc(0, 16'h3000, 4'h0);
`endif
    drive_check(1, 16'h3000, 4'h0);
    chk("reset_fetchh_idle", 64'({Mem_WR, Mem_CS, IR_Enable}), 64'b0_1_0);
    clock_edge();
    drive_check(0, 16'h3000, 4'h0);
    chk("reset_fetchh_init", 64'(ARF_RegSel), 64'h7);
`ifdef CTRL_INSTR_COUNT_EN
    chk("count_cleared", 64'(InstrCount), 64'd0);
`endif
    clock_edge();
    // Randomized traffic with occasional resets; halts are kept rare.
    for (int i = 0; i < 600; i++) begin
      rir = 16'($urandom);
      if (rir[15:12] == 4'hF && $urandom_range(0, 3) != 0) rir[15:12] = 4'h5;
      rr = ($urandom_range(0, 99) < 3);
      cyc(rr, rir, 4'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
